blackboxed_regs_ctrl: RTL and testbench

Access controller for a `BlackBoxedRegs` register-file instance.
- Presents separate valid/ready write-request, read-request and read-response channels.
- Arbitrates both request channels onto the array's single shared index port (`i`/`d`/`en`, combinational `q`).
- Clears every entry after reset.
- Sits between pipeline/CSR logic and the black-boxed array, which has no reset and no arbitration of its own.

---
 rtl/blackboxed_regs_pkg.sv | 32 +++
 rtl/blackboxed_regs_ctrl_rr_arb2.sv | 39 +++
 rtl/blackboxed_regs_ctrl.sv | 156 +++++++++++++++
 tb/tb_blackboxed_regs_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackboxed_regs_pkg.sv
// Shared types for the BlackBoxedRegs access controller: FSM states and the
// decoded arbitration grant.
package blackboxed_regs_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } grant_t;

    // Requester positions on the two-way arbiter.
    localparam int GNT_WR_BIT = 0;
    localparam int GNT_RD_BIT = 1;

    function automatic grant_t decode_grant(input logic [1:0] gnt);
        grant_t g;
        g = NONE;
        if (gnt[GNT_WR_BIT]) begin
            g = WR;
        end else if (gnt[GNT_RD_BIT]) begin
            g = RD;
        end
        return g;
    endfunction

endpackage

// File: rtl/blackboxed_regs_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester always wins; under
// contention the pointer picks the winner and flips after that grant.
module rr_arb2
    import blackboxed_regs_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_reg;
    logic ptr_next;
    logic contested;

    assign contested = req[GNT_WR_BIT] && req[GNT_RD_BIT];

    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr_reg;
        if (contested) begin
            // ptr=0 favours the write side.
            gnt[GNT_WR_BIT] = ~ptr_reg;
            gnt[GNT_RD_BIT] = ptr_reg;
            ptr_next        = ~ptr_reg;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/blackboxed_regs_ctrl.sv
// Access controller for a reset-less register array: clears it after reset,
// then arbitrates write and read requests onto its single index port.
module blackboxed_regs_ctrl
    import blackboxed_regs_pkg::*;
#(
    parameter int                 NREGS      = 32,
    parameter int                 WIDTH      = 64,
    parameter int                 IDXWIDTH   = 5,
    parameter logic [WIDTH-1:0]   INIT_VALUE = '0
)
(
    input  logic                clk,
    input  logic                rst_n,

    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [IDXWIDTH-1:0] wr_idx,
    input  logic [WIDTH-1:0]    wr_data,

    input  logic                rd_valid,
    output logic                rd_ready,
    input  logic [IDXWIDTH-1:0] rd_idx,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
    output logic                rsp_err,

    output logic                init_done,

    output logic [IDXWIDTH-1:0] reg_i,
    output logic [WIDTH-1:0]    reg_d,
    output logic                reg_en,
    input  logic [WIDTH-1:0]    reg_q
);

    localparam logic [IDXWIDTH:0]   NREGS_EXT = (IDXWIDTH+1)'(NREGS);
    localparam logic [IDXWIDTH-1:0] LAST_IDX  = IDXWIDTH'(NREGS - 1);

    state_t              state_reg;
    state_t              state_next;
    logic [IDXWIDTH-1:0] cnt_reg;
    logic [IDXWIDTH-1:0] cnt_next;
    logic                init_done_reg;
    logic [IDXWIDTH-1:0] reg_i_reg;
    logic [WIDTH-1:0]    reg_d_reg;

    logic                rsp_valid_reg;
    logic [WIDTH-1:0]    rsp_data_reg;
    logic                rsp_err_reg;

    logic                slot_free;
    logic                wr_in_range;
    logic                rd_in_range;
    logic [1:0]          req;
    logic [1:0]          gnt;
    grant_t              grant;

    assign wr_in_range = ({1'b0, wr_idx} < NREGS_EXT);
    assign rd_in_range = ({1'b0, rd_idx} < NREGS_EXT);

    // A read may only compete when its response has somewhere to land, so a
    // stalled response never steals array slots from writes.
    assign slot_free         = !rsp_valid_reg || rsp_ready;
    assign req[GNT_WR_BIT]   = (state_reg == RUN) && wr_valid;
    assign req[GNT_RD_BIT]   = (state_reg == RUN) && rd_valid && slot_free;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign grant    = decode_grant(gnt);
    assign wr_ready = gnt[GNT_WR_BIT];
    assign rd_ready = gnt[GNT_RD_BIT];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        reg_i      = reg_i_reg;
        reg_d      = reg_d_reg;
        reg_en     = 1'b0;
        case (state_reg)
            BOOT: begin
                state_next = INIT;
            end
            INIT: begin
                reg_i  = cnt_reg;
                reg_d  = INIT_VALUE;
                reg_en = 1'b1;
                if (cnt_reg == LAST_IDX) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                case (grant)
                    WR: begin
                        reg_i  = wr_idx;
                        reg_d  = wr_data;
                        reg_en = wr_in_range;
                    end
                    RD: begin
                        reg_i = rd_idx;
                    end
                    default: ;
                endcase
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= BOOT;
            cnt_reg       <= '0;
            init_done_reg <= 1'b0;
            reg_i_reg     <= '0;
            reg_d_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            init_done_reg <= (state_next == RUN);
            reg_i_reg     <= reg_i;
            reg_d_reg     <= reg_d;
        end
    end

    // The array output is captured at accept time, so later writes to the
    // same index cannot disturb a response waiting for rsp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else if (grant == RD) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= rd_in_range ? reg_q : '0;
            rsp_err_reg   <= !rd_in_range;
        end else if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign init_done = init_done_reg;

endmodule

// File: tb/tb_blackboxed_regs_ctrl.sv
// Bench for blackboxed_regs_ctrl: a behavioural reset-less array on the reg_*
// port and a reference model of contents, arbitration and the response slot.
module tb_blackboxed_regs_ctrl;

    localparam int          NREGS    = 32;
    localparam int          WIDTH    = 64;
    localparam int          IDXW     = 6;
    localparam logic [63:0] INIT_VAL = 64'hA5A5_0000_0000_5A5A;
    localparam logic [63:0] OOR_Q    = 64'hDEAD_BEEF_0BAD_F00D;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_valid, wr_ready;
    logic [IDXW-1:0]  wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid, rd_ready;
    logic [IDXW-1:0]  rd_idx;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic             init_done;
    logic [IDXW-1:0]  reg_i;
    logic [WIDTH-1:0] reg_d;
    logic             reg_en;
    logic [WIDTH-1:0] reg_q;

    int checks   = 0;
    int failures = 0;
    int tb_ptr   = 0;

    logic [WIDTH-1:0] mem     [NREGS];
    logic [WIDTH-1:0] ref_mem [NREGS];

    always #5 clk = ~clk;

    blackboxed_regs_ctrl #(
        .NREGS      (NREGS),
        .WIDTH      (WIDTH),
        .IDXWIDTH   (IDXW),
        .INIT_VALUE (INIT_VAL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_idx    (rd_idx),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .init_done (init_done),
        .reg_i     (reg_i),
        .reg_d     (reg_d),
        .reg_en    (reg_en),
        .reg_q     (reg_q)
    );

    // Behavioural stand-in for the black-boxed array: no reset, comb read.
    always @(posedge clk) begin
        if (reg_en && reg_i < 6'd32) mem[reg_i[4:0]] <= reg_d;
    end
    assign reg_q = (reg_i < 6'd32) ? mem[reg_i[4:0]] : OOR_Q;

    task automatic ref_clear();
        for (int i = 0; i < NREGS; i++) ref_mem[i] = INIT_VAL;
    endtask

    task automatic idle();
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        wr_idx = '0; wr_data = '0; rd_idx = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got %b exp 0", wr_ready); end
        checks++; if (rd_ready !== 1'b0) begin failures++; $display("FAIL reset_rd_ready got %b exp 0", rd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 64'h0) begin failures++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got %b exp 0", init_done); end
        checks++; if (reg_en !== 1'b0) begin failures++; $display("FAIL reset_reg_en got %b exp 0", reg_en); end
        checks++; if (reg_i !== 6'h0) begin failures++; $display("FAIL reset_reg_i got %h exp 0", reg_i); end
        checks++; if (reg_d !== 64'h0) begin failures++; $display("FAIL reset_reg_d got %h exp 0", reg_d); end
        // Release with both requests pending: nothing may be granted before RUN.
        @(negedge clk);
        rst_n = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1;
        #1;
        checks++; if (reg_en !== 1'b0) begin failures++; $display("FAIL boot_reg_en got %b exp 0", reg_en); end
        for (int k = 1; k <= NREGS; k++) begin
            @(negedge clk); #1;
            checks++; if (reg_en !== 1'b1 || reg_i !== 6'(k - 1) || reg_d !== INIT_VAL)
                begin failures++; $display("FAIL init_sweep cycle %0d got en=%b i=%0d d=%h exp en=1 i=%0d d=%h", k, reg_en, reg_i, reg_d, k - 1, INIT_VAL); end
            checks++; if (init_done !== 1'b0 || wr_ready !== 1'b0 || rd_ready !== 1'b0)
                begin failures++; $display("FAIL init_quiet cycle %0d got done=%b wr_rdy=%b rd_rdy=%b exp 0 0 0", k, init_done, wr_ready, rd_ready); end
        end
        @(negedge clk);
        idle();
        #1;
        checks++; if (init_done !== 1'b1 || reg_en !== 1'b0)
            begin failures++; $display("FAIL init_done_rise got done=%b en=%b exp 1 0", init_done, reg_en); end
        ref_clear();
        tb_ptr = 0;
    endtask

    task automatic test_init_readback();
        for (int i = 0; i <= NREGS; i++) begin
            @(negedge clk);
            if (i < NREGS) begin rd_valid = 1'b1; rd_idx = 6'(i); end
            else rd_valid = 1'b0;
            #1;
            if (i < NREGS) begin
                checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL readback_ready idx %0d got %b exp 1", i, rd_ready); end
            end
            if (i > 0) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[i - 1] || rsp_err !== 1'b0)
                    begin failures++; $display("FAIL readback idx %0d got v=%b d=%h e=%b exp 1 %h 0", i - 1, rsp_valid, rsp_data, rsp_err, ref_mem[i - 1]); end
            end
        end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL readback_drain got %b exp 0", rsp_valid); end
    endtask

    task automatic test_write_read();
        int widx, ridx;
        logic [63:0] wdat;
        for (int n = 0; n < 25; n++) begin
            widx = (n == 0) ? 5 : int'($urandom_range(0, 31));
            wdat = (n == 0) ? 64'hDEAD : {$urandom, $urandom};
            ridx = (n == 0 || $urandom_range(0, 1) == 1) ? widx : int'($urandom_range(0, 31));
            @(negedge clk);
            wr_valid = 1'b1; wr_idx = 6'(widx); wr_data = wdat;
            #1;
            checks++; if (wr_ready !== 1'b1 || reg_en !== 1'b1 || reg_i !== 6'(widx) || reg_d !== wdat)
                begin failures++; $display("FAIL write_port got rdy=%b en=%b i=%0d d=%h exp 1 1 %0d %h", wr_ready, reg_en, reg_i, reg_d, widx, wdat); end
            ref_mem[widx] = wdat;
            @(negedge clk);
            wr_valid = 1'b0; rd_valid = 1'b1; rd_idx = 6'(ridx);
            #1;
            checks++; if (rd_ready !== 1'b1 || reg_en !== 1'b0 || reg_i !== 6'(ridx))
                begin failures++; $display("FAIL read_port got rdy=%b en=%b i=%0d exp 1 0 %0d", rd_ready, reg_en, reg_i, ridx); end
            @(negedge clk);
            rd_valid = 1'b0;
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[ridx] || rsp_err !== 1'b0)
                begin failures++; $display("FAIL write_then_read idx %0d got v=%b d=%h e=%b exp 1 %h 0", ridx, rsp_valid, rsp_data, rsp_err, ref_mem[ridx]); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int widx, ridx;
        logic [63:0] wdat;
        logic exp_w;
        logic pend;
        logic [63:0] pend_d;
        pend = 1'b0; pend_d = '0;
        // Five contested cycles starting from ptr=0: W,R,W,R then W again.
        for (int c = 0; c < 5; c++) begin
            widx = int'($urandom_range(0, 31));
            ridx = int'($urandom_range(0, 31));
            wdat = {$urandom, $urandom};
            @(negedge clk);
            wr_valid = 1'b1; wr_idx = 6'(widx); wr_data = wdat;
            rd_valid = 1'b1; rd_idx = 6'(ridx); rsp_ready = 1'b1;
            #1;
            exp_w = (c % 2 == 0);
            checks++; if (wr_ready !== exp_w || rd_ready !== !exp_w)
                begin failures++; $display("FAIL rr_grant cycle %0d got wr=%b rd=%b exp wr=%b rd=%b", c, wr_ready, rd_ready, exp_w, !exp_w); end
            checks++; if (rsp_valid !== pend || (pend && rsp_data !== pend_d))
                begin failures++; $display("FAIL rr_rsp cycle %0d got v=%b d=%h exp v=%b d=%h", c, rsp_valid, rsp_data, pend, pend_d); end
            if (exp_w) begin
                ref_mem[widx] = wdat;
                pend = 1'b0;
            end else begin
                pend = 1'b1;
                pend_d = ref_mem[ridx];
            end
            tb_ptr = 1 - tb_ptr;
        end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rr_end_rsp got %b exp 0", rsp_valid); end
    endtask

    task automatic test_stall();
        logic [63:0] old;
        @(negedge clk);
        rd_valid = 1'b1; rd_idx = 6'd3; rsp_ready = 1'b0;
        #1;
        checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL stall_first_read got %b exp 1", rd_ready); end
        old = ref_mem[3];
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_idx = 6'd3; wr_data = 64'(s + 1);
            #1;
            checks++; if (rd_ready !== 1'b0 || wr_ready !== 1'b1)
                begin failures++; $display("FAIL stall_ready cycle %0d got rd=%b wr=%b exp 0 1", s, rd_ready, wr_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== old)
                begin failures++; $display("FAIL stall_hold cycle %0d got v=%b d=%h exp 1 %h", s, rsp_valid, rsp_data, old); end
            ref_mem[3] = 64'(s + 1);
        end
        @(negedge clk);
        wr_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        checks++; if (rd_ready !== 1'b1 || rsp_data !== old)
            begin failures++; $display("FAIL stall_drain got rd=%b d=%h exp 1 %h", rd_ready, rsp_data, old); end
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[3])
            begin failures++; $display("FAIL stall_reread got v=%b d=%h exp 1 %h", rsp_valid, rsp_data, ref_mem[3]); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_end got %b exp 0", rsp_valid); end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        rd_valid = 1'b1; rd_idx = 6'd40;
        #1;
        checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL oor_read_ready got %b exp 1", rd_ready); end
        @(negedge clk);
        rd_valid = 1'b0; wr_valid = 1'b1; wr_idx = 6'd40; wr_data = {$urandom, $urandom};
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h0 || rsp_err !== 1'b1)
            begin failures++; $display("FAIL oor_read_rsp got v=%b d=%h e=%b exp 1 0 1", rsp_valid, rsp_data, rsp_err); end
        checks++; if (wr_ready !== 1'b1 || reg_en !== 1'b0 || reg_i !== 6'd40)
            begin failures++; $display("FAIL oor_write got rdy=%b en=%b i=%0d exp 1 0 40", wr_ready, reg_en, reg_i); end
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_idx = 6'd8;
        #1;
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[8] || rsp_err !== 1'b0)
            begin failures++; $display("FAIL oor_alias got v=%b d=%h e=%b exp 1 %h 0", rsp_valid, rsp_data, rsp_err, ref_mem[8]); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic wv, rv, rr, gw, gr, rd_ok;
        int widx, ridx;
        logic [63:0] wdat;
        logic exp_v, exp_e;
        logic [63:0] exp_d;
        exp_v = 1'b0; exp_e = 1'b0; exp_d = '0;
        for (int n = 0; n < 300; n++) begin
            wv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 3) != 0);
            widx = int'($urandom_range(0, 39));
            ridx = int'($urandom_range(0, 39));
            wdat = {$urandom, $urandom};
            @(negedge clk);
            wr_valid = wv; wr_idx = 6'(widx); wr_data = wdat;
            rd_valid = rv; rd_idx = 6'(ridx); rsp_ready = rr;
            #1;
            checks++; if (rsp_valid !== exp_v || (exp_v && (rsp_data !== exp_d || rsp_err !== exp_e)))
                begin failures++; $display("FAIL rand_rsp iter %0d got v=%b d=%h e=%b exp v=%b d=%h e=%b", n, rsp_valid, rsp_data, rsp_err, exp_v, exp_d, exp_e); end
            rd_ok = rv && (!exp_v || rr);
            if (wv && rd_ok) begin
                gw = (tb_ptr == 0); gr = !gw; tb_ptr = 1 - tb_ptr;
            end else begin
                gw = wv; gr = rd_ok;
            end
            checks++; if (wr_ready !== gw || rd_ready !== gr)
                begin failures++; $display("FAIL rand_grant iter %0d got wr=%b rd=%b exp wr=%b rd=%b", n, wr_ready, rd_ready, gw, gr); end
            if (gw) begin
                checks++; if (reg_en !== (widx < NREGS))
                    begin failures++; $display("FAIL rand_reg_en iter %0d got %b exp %b", n, reg_en, widx < NREGS); end
                if (widx < NREGS) ref_mem[widx] = wdat;
            end
            if (gr) begin
                exp_v = 1'b1;
                exp_d = (ridx < NREGS) ? ref_mem[ridx] : 64'h0;
                exp_e = (ridx >= NREGS);
            end else if (exp_v && rr) begin
                exp_v = 1'b0;
            end
        end
        @(negedge clk);
        idle();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int waited;
        @(negedge clk);
        wr_valid = 1'b1; wr_idx = 6'd12; wr_data = 64'h1234_5678_9ABC_DEF0;
        #1;
        ref_mem[12] = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_idx = 6'd12; rsp_ready = 1'b0;
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[12])
            begin failures++; $display("FAIL midrst_pending got v=%b d=%h exp 1 %h", rsp_valid, rsp_data, ref_mem[12]); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 64'h0 || init_done !== 1'b0 || reg_en !== 1'b0 || reg_i !== 6'h0)
            begin failures++; $display("FAIL midrst_async got v=%b d=%h done=%b en=%b i=%0d exp 0 0 0 0 0", rsp_valid, rsp_data, init_done, reg_en, reg_i); end
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        ref_clear();
        tb_ptr = 0;
        waited = 0;
        for (int w = 1; w <= 100; w++) begin
            @(negedge clk); #1;
            waited = w;
            if (init_done) break;
        end
        checks++; if (init_done !== 1'b1 || waited != NREGS + 1)
            begin failures++; $display("FAIL midrst_reinit got done=%b after %0d cycles exp 1 after %0d", init_done, waited, NREGS + 1); end
        test_init_readback();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init_readback();
        test_write_read();
        test_back_to_back();
        test_stall();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
